// File: rtl/word_packer_pkg.sv
// Shared definitions for the word packer: FSM state encoding, PUF-wide widths
// and the ceiling-log2 helper used to size the beat counter.
package word_packer_pkg;

  localparam int PUF_RESP_W = 264;
  localparam int PUF_BEAT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/word_packer_slot_wr.sv
// Combinational slot writer: returns the buffer with one beat placed into the
// slot selected by index, honouring the beat order chosen by MSB_FIRST.
module word_packer_slot_wr
  import word_packer_pkg::*;
#(
  parameter int SZ_IN     = PUF_BEAT_W,
  parameter int SZ_OUT    = PUF_RESP_W,
  parameter int MSB_FIRST = 1,
  parameter int CW        = clog2(SZ_OUT / SZ_IN + 1)
) (
  input  logic [SZ_OUT-1:0] buffer,
  input  logic [SZ_IN-1:0]  beat,
  input  logic [CW-1:0]     index,
  output logic [SZ_OUT-1:0] updated
);

  localparam int COUNT = SZ_OUT / SZ_IN;

  // Overwrite only the addressed slot; an index past the last slot leaves the buffer as is.
  always_comb begin
    updated = buffer;
    for (int k = 0; k < COUNT; k++) begin
      if (index == CW'(k)) begin
        if (MSB_FIRST != 0) updated[SZ_OUT-1-k*SZ_IN -: SZ_IN] = beat;
        else                updated[k*SZ_IN +: SZ_IN]          = beat;
      end
    end
  end

endmodule

// File: rtl/word_packer.sv
// Packs a stream of SZ_IN-bit beats into one SZ_OUT-bit word with valid/ready
// on both sides, early flush of partial words, optional continuous framing
// and a sticky overrun flag for beats offered while the word is being held.
// SZ_OUT must be an integer multiple of SZ_IN.
module word_packer
  import word_packer_pkg::*;
#(
  parameter int SZ_IN      = PUF_BEAT_W,
  parameter int SZ_OUT     = PUF_RESP_W,
  parameter int MSB_FIRST  = 1,
  parameter int CONTINUOUS = 0,
  localparam int COUNT     = SZ_OUT / SZ_IN,
  localparam int CW        = clog2(COUNT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic [SZ_IN-1:0]  data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SZ_OUT-1:0] data_out,
  output logic [CW-1:0]     out_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overrun
);

  state_t            state;
  logic [SZ_OUT-1:0] buffer;
  logic [SZ_OUT-1:0] wr_buffer;
  logic [SZ_OUT-1:0] fill_buffer;
  logic [CW-1:0]     count;
  logic [CW-1:0]     fill_count;
  logic              accept;
  logic              fill_done;

  word_packer_slot_wr #(
    .SZ_IN    (SZ_IN),
    .SZ_OUT   (SZ_OUT),
    .MSB_FIRST(MSB_FIRST),
    .CW       (CW)
  ) u_slot_wr (
    .buffer (buffer),
    .beat   (data_in),
    .index  (count),
    .updated(wr_buffer)
  );

  // Buffer and count as they would be after this cycle's beat, and whether the word closes now.
  always_comb begin
    accept      = in_valid & in_ready;
    fill_buffer = accept ? wr_buffer : buffer;
    fill_count  = accept ? count + CW'(1) : count;
    fill_done   = (accept && (count == CW'(COUNT - 1))) ||
                  (flush && (fill_count != '0));
  end

  // Frame FSM with all handshake and status outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      buffer    <= '0;
      count     <= '0;
      data_out  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FILL;
            buffer   <= '0;
            count    <= '0;
            overrun  <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        FILL: begin
          if (start) begin
            buffer  <= '0;
            count   <= '0;
            overrun <= 1'b0;
          end else if (fill_done) begin
            state     <= HOLD;
            buffer    <= fill_buffer;
            count     <= fill_count;
            data_out  <= fill_buffer;
            out_count <= fill_count;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
          end else begin
            buffer <= fill_buffer;
            count  <= fill_count;
          end
        end
        HOLD: begin
          if (in_valid) overrun <= 1'b1;
          if (out_ready) begin
            out_valid <= 1'b0;
            buffer    <= '0;
            count     <= '0;
            if (CONTINUOUS != 0) begin
              state    <= FILL;
              in_ready <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          buffer    <= '0;
          count     <= '0;
          data_out  <= '0;
          out_count <= '0;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
          busy      <= 1'b0;
          overrun   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_packer.sv
// Self-checking bench for word_packer. Four instances share one stimulus
// stream: MSB-first, LSB-first, continuous and a full 264-bit build. Expected
// words come from a packing model over the queue of beats actually sent.
module tb_word_packer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [31:0]  m_data_out, l_data_out, c_data_out;
  logic [263:0] w_data_out;
  logic [2:0]   m_out_count, l_out_count, c_out_count;
  logic [5:0]   w_out_count;
  logic m_in_ready, m_out_valid, m_busy, m_overrun;
  logic l_in_ready, l_out_valid, l_busy, l_overrun;
  logic c_in_ready, c_out_valid, c_busy, c_overrun;
  logic w_in_ready, w_out_valid, w_busy, w_overrun;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] sent[$];

  always #5 clk = ~clk;

  word_packer #(.SZ_IN(8), .SZ_OUT(32), .MSB_FIRST(1), .CONTINUOUS(0)) u_msb (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .data_in(data_in),
    .in_valid(in_valid), .in_ready(m_in_ready), .data_out(m_data_out),
    .out_count(m_out_count), .out_valid(m_out_valid), .out_ready(out_ready),
    .busy(m_busy), .overrun(m_overrun));

  word_packer #(.SZ_IN(8), .SZ_OUT(32), .MSB_FIRST(0), .CONTINUOUS(0)) u_lsb (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .data_in(data_in),
    .in_valid(in_valid), .in_ready(l_in_ready), .data_out(l_data_out),
    .out_count(l_out_count), .out_valid(l_out_valid), .out_ready(out_ready),
    .busy(l_busy), .overrun(l_overrun));

  word_packer #(.SZ_IN(8), .SZ_OUT(32), .MSB_FIRST(1), .CONTINUOUS(1)) u_cont (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .data_in(data_in),
    .in_valid(in_valid), .in_ready(c_in_ready), .data_out(c_data_out),
    .out_count(c_out_count), .out_valid(c_out_valid), .out_ready(out_ready),
    .busy(c_busy), .overrun(c_overrun));

  word_packer #(.SZ_IN(8), .SZ_OUT(264), .MSB_FIRST(1), .CONTINUOUS(0)) u_wide (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .data_in(data_in),
    .in_valid(in_valid), .in_ready(w_in_ready), .data_out(w_data_out),
    .out_count(w_out_count), .out_valid(w_out_valid), .out_ready(out_ready),
    .busy(w_busy), .overrun(w_overrun));

  // Expected word: beats concatenated in arrival order, unused slots left zero.
  function automatic logic [263:0] model_word(input int slots, input bit msb);
    logic [263:0] acc;
    acc = '0;
    for (int i = 0; i < sent.size(); i++) begin
      if (msb) acc = (acc << 8) | 264'(sent[i]);
      else     acc = acc | (264'(sent[i]) << (8 * i));
    end
    if (msb) acc = acc << (8 * (slots - sent.size()));
    return acc;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; in_valid = 1'b0; data_in = 8'h00;
    #7;
    rst = 1'b0;
    step();
    sent.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    sent.delete();
  endtask

  task automatic send_beat(input logic [7:0] b, input bit with_flush);
    data_in = b; in_valid = 1'b1; flush = with_flush;
    sent.push_back(b);
    step();
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    vectors++;
    if ({m_in_ready, m_out_valid, m_busy, m_overrun, l_in_ready, l_out_valid, l_busy, l_overrun} !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_flags_ml got %b want 00000000",
               {m_in_ready, m_out_valid, m_busy, m_overrun, l_in_ready, l_out_valid, l_busy, l_overrun});
    end
    vectors++;
    if ({c_in_ready, c_out_valid, c_busy, c_overrun, w_in_ready, w_out_valid, w_busy, w_overrun} !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_flags_cw got %b want 00000000",
               {c_in_ready, c_out_valid, c_busy, c_overrun, w_in_ready, w_out_valid, w_busy, w_overrun});
    end
    vectors++;
    if (m_data_out !== 32'h0 || l_data_out !== 32'h0 || c_data_out !== 32'h0 || w_data_out !== 264'h0 ||
        m_out_count !== 3'd0 || l_out_count !== 3'd0 || c_out_count !== 3'd0 || w_out_count !== 6'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_data got m=%h/%0d l=%h/%0d c=%h/%0d want all zero",
               m_data_out, m_out_count, l_data_out, l_out_count, c_data_out, c_out_count);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_word();
    logic [263:0] exp_m, exp_l;
    do_reset();
    out_ready = 1'b1;
    for (int iter = 0; iter < 4; iter++) begin
      pulse_start();
      for (int i = 0; i < 4; i++) begin
        if (iter > 0 && $urandom_range(0, 1) == 1) step();
        send_beat(iter == 0 ? 8'(17 * (i + 1)) : 8'($urandom), 1'b0);
      end
      exp_m = model_word(4, 1'b1);
      exp_l = model_word(4, 1'b0);
      vectors++;
      if (m_out_valid !== 1'b1 || m_data_out !== exp_m[31:0] || m_out_count !== 3'd4) begin
        miscompares++;
        $display("[TB] FAIL full_msb got valid=%b data=%h count=%0d want valid=1 data=%h count=4",
                 m_out_valid, m_data_out, m_out_count, exp_m[31:0]);
      end
      vectors++;
      if (l_out_valid !== 1'b1 || l_data_out !== exp_l[31:0] || l_out_count !== 3'd4) begin
        miscompares++;
        $display("[TB] FAIL full_lsb got valid=%b data=%h count=%0d want valid=1 data=%h count=4",
                 l_out_valid, l_data_out, l_out_count, exp_l[31:0]);
      end
      step();
      vectors++;
      if (m_out_valid !== 1'b0 || m_in_ready !== 1'b0 || m_busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL full_to_idle got valid=%b in_ready=%b busy=%b want 0 0 0",
                 m_out_valid, m_in_ready, m_busy);
      end
    end
  endtask

  task automatic test_flush();
    logic [263:0] exp_m, exp_l;
    int n;
    bit last_flush;
    do_reset();
    out_ready = 1'b1;
    for (int iter = 0; iter < 4; iter++) begin
      pulse_start();
      n = (iter == 0) ? 3 : int'($urandom_range(1, 3));
      last_flush = (iter == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      for (int i = 0; i < n; i++)
        send_beat(iter == 0 ? 8'(170 + 17 * i) : 8'($urandom), (i == n - 1) && last_flush);
      if (!last_flush) begin
        flush = 1'b1;
        step();
        flush = 1'b0;
      end
      exp_m = model_word(4, 1'b1);
      exp_l = model_word(4, 1'b0);
      vectors++;
      if (m_out_valid !== 1'b1 || m_data_out !== exp_m[31:0] || m_out_count !== 3'(n)) begin
        miscompares++;
        $display("[TB] FAIL flush_msb got valid=%b data=%h count=%0d want valid=1 data=%h count=%0d",
                 m_out_valid, m_data_out, m_out_count, exp_m[31:0], n);
      end
      vectors++;
      if (l_out_valid !== 1'b1 || l_data_out !== exp_l[31:0] || l_out_count !== 3'(n)) begin
        miscompares++;
        $display("[TB] FAIL flush_lsb got valid=%b data=%h count=%0d want valid=1 data=%h count=%0d",
                 l_out_valid, l_data_out, l_out_count, exp_l[31:0], n);
      end
      step();
    end
    pulse_start();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    vectors++;
    if (m_out_valid !== 1'b0 || m_busy !== 1'b1 || m_in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_empty got valid=%b busy=%b in_ready=%b want 0 1 1",
               m_out_valid, m_busy, m_in_ready);
    end
  endtask

  task automatic test_continuous();
    logic [263:0] exp_c;
    do_reset();
    out_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 4; i++) send_beat(8'($urandom), 1'b0);
    exp_c = model_word(4, 1'b1);
    vectors++;
    if (c_out_valid !== 1'b1 || c_data_out !== exp_c[31:0]) begin
      miscompares++;
      $display("[TB] FAIL cont_first got valid=%b data=%h want valid=1 data=%h", c_out_valid, c_data_out, exp_c[31:0]);
    end
    for (int i = 0; i < 5; i++) begin
      data_in = 8'($urandom);
      in_valid = 1'b1;
      step();
      vectors++;
      if (c_data_out !== exp_c[31:0] || c_in_ready !== 1'b0 || c_out_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL cont_hold got data=%h in_ready=%b valid=%b want data=%h in_ready=0 valid=1",
                 c_data_out, c_in_ready, c_out_valid, exp_c[31:0]);
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (c_overrun !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL cont_overrun got %b want 1", c_overrun);
    end
    out_ready = 1'b1;
    step();
    vectors++;
    if (c_out_valid !== 1'b0 || c_in_ready !== 1'b1 || c_busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL cont_refill got valid=%b in_ready=%b busy=%b want 0 1 1", c_out_valid, c_in_ready, c_busy);
    end
    sent.delete();
    for (int i = 0; i < 4; i++) send_beat(8'($urandom), 1'b0);
    exp_c = model_word(4, 1'b1);
    vectors++;
    if (c_out_valid !== 1'b1 || c_data_out !== exp_c[31:0] || c_out_count !== 3'd4) begin
      miscompares++;
      $display("[TB] FAIL cont_second got valid=%b data=%h count=%0d want valid=1 data=%h count=4",
               c_out_valid, c_data_out, c_out_count, exp_c[31:0]);
    end
    step();
    vectors++;
    if (c_overrun !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL cont_sticky got %b want 1", c_overrun);
    end
    pulse_start();
    vectors++;
    if (c_overrun !== 1'b0 || c_in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL cont_start_clear got overrun=%b in_ready=%b want 0 1", c_overrun, c_in_ready);
    end
  endtask

  task automatic test_restart();
    logic [263:0] exp_m;
    do_reset();
    out_ready = 1'b0;
    pulse_start();
    send_beat(8'($urandom), 1'b0);
    send_beat(8'($urandom), 1'b0);
    start = 1'b1; data_in = 8'($urandom); in_valid = 1'b1;
    step();
    start = 1'b0; in_valid = 1'b0;
    sent.delete();
    for (int i = 0; i < 4; i++) send_beat(8'(i + 1), 1'b0);
    exp_m = model_word(4, 1'b1);
    vectors++;
    if (m_out_valid !== 1'b1 || m_data_out !== exp_m[31:0] || m_out_count !== 3'd4) begin
      miscompares++;
      $display("[TB] FAIL restart got valid=%b data=%h count=%0d want valid=1 data=%h count=4",
               m_out_valid, m_data_out, m_out_count, exp_m[31:0]);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if (m_out_valid !== 1'b1 || m_data_out !== exp_m[31:0]) begin
      miscompares++;
      $display("[TB] FAIL start_in_hold got valid=%b data=%h want valid=1 data=%h", m_out_valid, m_data_out, exp_m[31:0]);
    end
    out_ready = 1'b1;
    step();
    vectors++;
    if (m_out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL restart_release got valid=%b want 0", m_out_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b1;
    pulse_start();
    send_beat(8'($urandom), 1'b0);
    send_beat(8'($urandom), 1'b0);
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({m_in_ready, m_out_valid, m_busy, m_overrun} !== 4'b0 || m_data_out !== 32'h0 || m_out_count !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL async_fill got flags=%b data=%h count=%0d want 0000 0 0",
               {m_in_ready, m_out_valid, m_busy, m_overrun}, m_data_out, m_out_count);
    end
    rst = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      data_in = 8'($urandom);
      in_valid = 1'b1;
      step();
      vectors++;
      if (m_out_valid !== 1'b0 || m_in_ready !== 1'b0 || m_busy !== 1'b0 || m_overrun !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL idle_after_reset got valid=%b in_ready=%b busy=%b overrun=%b want 0 0 0 0",
                 m_out_valid, m_in_ready, m_busy, m_overrun);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 4; i++) send_beat(8'($urandom), 1'b0);
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (m_out_valid !== 1'b0 || m_busy !== 1'b0 || m_data_out !== 32'h0 || m_out_count !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL async_hold got valid=%b busy=%b data=%h count=%0d want 0 0 0 0",
               m_out_valid, m_busy, m_data_out, m_out_count);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_wide();
    logic [263:0] exp_w;
    do_reset();
    out_ready = 1'b1;
    for (int iter = 0; iter < 2; iter++) begin
      pulse_start();
      for (int i = 0; i < 33; i++) send_beat(iter == 0 ? 8'(i) : 8'($urandom), 1'b0);
      exp_w = model_word(33, 1'b1);
      vectors++;
      if (w_out_valid !== 1'b1 || w_data_out !== exp_w || w_out_count !== 6'd33) begin
        miscompares++;
        $display("[TB] FAIL wide got valid=%b count=%0d data=%h want valid=1 count=33 data=%h",
                 w_out_valid, w_out_count, w_data_out, exp_w);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush();
    test_continuous();
    test_restart();
    test_async_reset();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard time limit so a stuck run still ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] time limit reached");
  end

endmodule

// File: doc/word_packer.md
Name: word_packer

Overview:
Parametrised successor to the team's byte-to-word accumulator. It packs a stream of SZ_IN-bit beats into one SZ_OUT-bit word, with a valid/ready handshake on both sides, selectable beat order and optional continuous framing. Early flush emits a zero-padded partial word, and an overrun flag reports beats that arrive while no beat is accepted. It sits between the RO-counter/comparator response stream and the PUF response consumers (UART/hash).

Parameters:
SZ_IN, 8, beat width in bits; must be >= 1.
SZ_OUT, 264, output word width; must be an integer multiple of SZ_IN.
MSB_FIRST, 1, 1 = first beat lands in the most significant slot; 0 = first beat lands in bits [SZ_IN-1:0].
CONTINUOUS, 0, 1 = return to FILL after each word is accepted; 0 = return to IDLE and wait for a new start.
Derived localparams: COUNT = SZ_OUT/SZ_IN; CW = clog2(COUNT+1).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse that opens a frame; clears the buffer and beat counter
flush  in  1  emit the current partial word
data_in  in  SZ_IN  input beat
in_valid  in  1  data_in valid
in_ready  out  1  beat accepted when in_valid & in_ready
data_out  out  SZ_OUT  packed word, stable while out_valid is high
out_count  out  CW  number of valid beats in data_out (COUNT for a full word)
out_valid  out  1  word available
out_ready  in  1  consumer accepts the word
busy  out  1  high in FILL or HOLD
overrun  out  1  sticky flag, cleared by start or rst

Behaviour:
- Reset (async, any state): state = IDLE. The buffer, data_out, out_count, counter, out_valid, overrun and busy are all 0. in_ready = 0.
- States:
  - IDLE: in_ready = 0. start -> FILL; the buffer and counter are cleared.
  - FILL: in_ready = 1. An accepted beat k (k = counter) is written to its slot:
    - MSB_FIRST = 1: bits [SZ_OUT-1-k*SZ_IN -: SZ_IN].
    - MSB_FIRST = 0: bits [k*SZ_IN +: SZ_IN].
    - counter then increments.
  - FILL -> HOLD when:
    - the accepted beat is the COUNT-th beat, or
    - flush is high with counter > 0 (after any beat accepted in the same cycle).
  - On the transition to HOLD: data_out <= buffer including the same-cycle beat; out_count <= beats held; out_valid <= 1.
  - HOLD: in_ready = 0; data_out and out_count are held. out_valid & out_ready -> out_valid = 0, buffer and counter cleared; next state is FILL if CONTINUOUS = 1, else IDLE.
- Unfilled slots of a flushed word are 0.
- Latency: the last beat accepted (or flush) at edge N gives out_valid = 1 after edge N. The earliest next beat is accepted in the cycle after the handshake.
- flush in FILL with counter = 0 and no beat that cycle: ignored. flush in IDLE or HOLD: ignored.
- start in FILL: the frame restarts. The buffer and counter are cleared, overrun is cleared, and a same-cycle beat is discarded.
- start in HOLD: ignored; the word is never dropped.
- start and flush in the same cycle: start wins.
- overrun <= 1 when in_valid = 1 and in_ready = 0 while busy (HOLD back-pressure). in_valid in IDLE does not set overrun.
- Counter never exceeds COUNT. out_count = 0 never occurs with out_valid = 1.
- Default/illegal state encoding -> IDLE with outputs cleared, matching reset.

Decomposition:
- Shared package/header: state encodings IDLE = 0, FILL = 1, HOLD = 2 (2-bit), and the clog2 function used for CW. PUF-wide widths (response length 264, beat 8) are also defined there.
- One sub-module is natural: word_packer_slot_wr. It is combinational and takes the buffer, beat, index and MSB_FIRST, and returns the updated buffer. Keep the FSM in the top.

Test Plan (SZ_IN = 8, SZ_OUT = 32, COUNT = 4 unless noted):
1. MSB_FIRST = 1, start, then beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles with out_ready = 1 -> out_valid for exactly one cycle, data_out = 0x11223344, out_count = 4; state returns to IDLE (in_ready = 0).
2. MSB_FIRST = 0, same beats -> data_out = 0x44332211, out_count = 4.
3. MSB_FIRST = 1, beats 0xAA, 0xBB, then flush together with beat 0xCC -> data_out = 0xAABBCC00, out_count = 3. A lone flush after start with no beats produces no output.
4. CONTINUOUS = 1, out_ready held 0 for 5 cycles after a full word while in_valid = 1 -> data_out stable, in_ready = 0, overrun = 1. After out_ready = 1 the next 4 beats are packed without a new start; a later start clears overrun.
5. start mid-frame after 2 beats, then 4 beats 0x01..0x04 -> data_out = 0x01020304; the earlier beats do not appear.
6. rst asserted asynchronously (between clock edges) during FILL and during HOLD -> all outputs 0 immediately. After release, no output until start. SZ_OUT = 264 regression: 33 beats 0x00..0x20 -> data_out = 0x000102..20 (MSB_FIRST = 1).
